amstrad_mmu_restore: RTL

- Bus-initiator engine that replays a stored memory-configuration state onto the CPC I/O write bus.
- It produces the ROM-select, gate-array RMR and PAL MMR writes that the memory-mapping logic decodes; it is the writer end of that interface.
- Used by the snapshot loader after RAM has been filled and before the Z80 is released.
- Owns the I/O bus only while its bus grant is held.

---
 rtl/amstrad_mmu_restore.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/amstrad_mmu_restore.sv
// amstrad_mmu_restore: replays a stored memory configuration (ROM select,
// gate-array RMR, PAL MMR) onto the CPC I/O write bus while the bus grant
// is held. Optional macro MMU_RESTORE_PALETTE_EN appends 17 pen/colour
// write pairs after the memory writes.
module amstrad_mmu_restore #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  input  logic        ram64k,
  input  logic [7:0]  rom_bank,
  input  logic [7:0]  rmr_val,
  input  logic [6:0]  mmr_val,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] io_A,
  output logic [7:0]  io_D,
  output logic        io_WR,
  output logic        busy,
  output logic        done,
  output logic [4:0]  pal_idx,
  input  logic [4:0]  pal_col
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_PULSE, S_HOLD, S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     idx_q, idx_d;
  logic           accept;

  // Shadow copy of the configuration taken on the accepted start
  logic [7:0]     rom_q;
  logic [3:0]     rmr_q;
  logic [6:0]     mmr_q;
  logic           r64_q;

  logic           bus_req_q, io_wr_q, busy_q, done_q;
  logic [15:0]    io_a_q;
  logic [7:0]     io_d_q;

  logic           setup_end, pulse_end, hold_end, last_wr;
  logic [5:0]     idx_next;
  logic [15:0]    wr_a;
  logic [7:0]     wr_d;
  logic           drive, own;

  assign setup_end = (cnt_q == CW'(SETUP_CYC - 1));
  assign pulse_end = (cnt_q == CW'(PULSE_CYC - 1));
  assign hold_end  = (cnt_q == CW'(HOLD_CYC - 1));

  // A 64K machine has no PAL, so the MMR slot is skipped
  assign idx_next = (idx_q == 6'd1 && r64_q) ? 6'd3 : idx_q + 6'd1;

`ifdef MMU_RESTORE_PALETTE_EN
  logic [4:0]     col_q;
  logic [4:0]     col_sel;
  logic           col_latch;
  logic [5:0]     pk;
  logic [4:0]     pen;
  logic [4:0]     pal_idx_q;

  assign last_wr   = (idx_q == 6'd36);
  // Colour is captured at the end of the colour write's setup phase, giving
  // the palette source a cycle of read latency after pal_idx changes.
  assign col_latch = (state_q == S_SETUP) && setup_end && bus_gnt;
  assign col_sel   = col_latch ? pal_col : col_q;
  assign pal_idx   = pal_idx_q;
`else
  logic unused_pal;
  assign unused_pal = ^pal_col;
  assign last_wr    = (idx_q == 6'd2) || (idx_q == 6'd1 && r64_q);
  assign pal_idx    = 5'd0;
`endif

  // Next-state logic for the write sequencer, including grant-loss retreat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = 6'd0;
          accept  = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (!bus_gnt) begin
          state_d = S_REQ;
        end else if (setup_end) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (!bus_gnt) begin
          state_d = S_REQ;
        end else if (pulse_end) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (!bus_gnt) begin
          state_d = S_REQ;
        end else if (hold_end) begin
          cnt_d = '0;
          if (last_wr) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_next;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address/data of the write that will be on the bus in the next cycle
  always_comb begin
    wr_a = '0;
    wr_d = '0;
`ifdef MMU_RESTORE_PALETTE_EN
    pk  = idx_d - 6'd3;
    pen = pk[5:1];
`endif
    case (idx_d)
      6'd0: begin
        wr_a = 16'hDF00;
        wr_d = rom_q;
      end
      6'd1: begin
        wr_a = 16'h7F00;
        wr_d = {4'b1000, rmr_q};
      end
      6'd2: begin
        wr_a = {7'b0111111, ~mmr_q[6], 8'h00};
        wr_d = {2'b11, mmr_q[5:0]};
      end
      default: begin
`ifdef MMU_RESTORE_PALETTE_EN
        wr_a = 16'h7F00;
        wr_d = pk[0] ? {3'b010, col_sel} : {3'b000, pen};
`endif
      end
    endcase
  end

  assign drive = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
  assign own   = drive || (state_d == S_REQ);

  // Sequencer state, phase counter and shadow configuration
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rom_q   <= '0;
      rmr_q   <= '0;
      mmr_q   <= '0;
      r64_q   <= 1'b0;
`ifdef MMU_RESTORE_PALETTE_EN
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (accept) begin
        rom_q <= rom_bank;
        rmr_q <= rmr_val[3:0];
        mmr_q <= mmr_val;
        r64_q <= ram64k;
      end
`ifdef MMU_RESTORE_PALETTE_EN
      if (col_latch) col_q <= pal_col;
`endif
    end
  end

  // Registered bus and status outputs, decoded from the next state
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      bus_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      io_wr_q   <= 1'b0;
      io_a_q    <= '0;
      io_d_q    <= '0;
`ifdef MMU_RESTORE_PALETTE_EN
      pal_idx_q <= '0;
`endif
    end else begin
      bus_req_q <= own;
      busy_q    <= own;
      done_q    <= (state_d == S_FIN);
      io_wr_q   <= (state_d == S_PULSE);
      io_a_q    <= drive ? wr_a : 16'h0000;
      io_d_q    <= drive ? wr_d : 8'h00;
`ifdef MMU_RESTORE_PALETTE_EN
      pal_idx_q <= (own && idx_d >= 6'd3) ? pen : 5'd0;
`endif
    end
  end

  assign bus_req = bus_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign io_WR   = io_wr_q;
  assign io_A    = io_a_q;
  assign io_D    = io_d_q;

endmodule
